muldiv_ctrl: RTL
================

# muldiv_ctrl

Sequencing controller for the MIPS HI/LO unit. It accepts MULT, DIV, MTHI and MTLO requests from the execute stage, latches the operands, and fires a start pulse to the multi-cycle multiplier or divider. It waits a fixed cycle count, then writes the result into the architectural HI/LO registers. It holds `busy` for pipeline stall and supports flush via `cancel`.

## Interface
- `MULT_CYCLES`, 34: run cycles from the multiplier start pulse to a valid result.
- `DIV_CYCLES`, 34: run cycles from the divider start pulse to a valid result.
- `CNT_W`, 6: counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  1  request valid; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- `a`, `b`  in  32  signed operands (MTHI/MTLO use `a`).
- `cancel`  in  1  pipeline flush; aborts the current operation.
- `mult_high`, `mult_low`  in  32  multiplier result.
- `div_quot`, `div_rem`  in  32  divider result.
- `op_a`, `op_b`  out  32  latched operands driven to both units.
- `mult_start`, `div_start`  out  1  one-cycle start pulses.
- `unit_clr`  out  1  one-cycle clear to both units.
- `busy`  out  1  stall request.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  one-cycle divide-by-zero flag (macro-dependent, see Configuration).
- `hi`, `lo`  out  32  architectural HI/LO.

## Operation
- **States:**
  - IDLE
  - MRUN: multiplier running.
  - DRUN: divider running.
- **IDLE, `req`=1, `cancel`=0:**
  - Latch `a`/`b` into `op_a`/`op_b`.
  - MULT → MRUN. DIV → DRUN.
  - MTHI/MTLO write `a` into `hi`/`lo` at that edge and stay in IDLE.
- **Run states:**
  - `busy`=1.
  - The counter clears on entry and increments each cycle.
  - `mult_start`/`div_start` = 1 only in the first run cycle (count 0).
- **Last run cycle (count = N-1):**
  - MRUN: `hi`←`mult_high`, `lo`←`mult_low`.
  - DRUN: `hi`←`div_rem`, `lo`←`div_quot`.
  - Return to IDLE.
- **`done`:** asserted for the one cycle after any HI/LO write, including MTHI/MTLO.
- **`req` while busy:** ignored, no queueing. The requester holds `req` until it sees `busy`=0.
- **`cancel`:**
  - In a run state: IDLE next edge, `hi`/`lo` unchanged, no `done`, `unit_clr`=1 the following cycle.
  - Beats completion when both occur in the final cycle.
  - In IDLE: suppresses acceptance of a simultaneous `req`.
- **Reset:**
  - `hi`=`lo`=0, `op_a`=`op_b`=0.
  - `busy`, `done`, `mult_start`, `div_start`, `div_zero` = 0.
  - `unit_clr`=1 for the first cycle after `rst` falls.
  - State IDLE.
  - Reset mid-run discards the operation.

## Timing
- **Accept:** `req` cycle T → run cycles T+1 … T+N.
  - Start pulse at T+1.
  - `hi`/`lo` updated at the end of T+N.
  - `done`=1 and `busy`=0 at T+N+1.
- **Back-to-back:** a new `req` is accepted in the `done` cycle.
- **MTHI/MTLO:** `req` at T → new value visible and `done`=1 at T+1; `busy` never rises.
- **Outputs:** all registered except `busy`, which is decoded from state.

## Configuration
- **`MULDIV_DIVZERO_EN` defined:**
  - DIV with `b`==0 does not enter DRUN and issues no `div_start`.
  - `div_zero`=1 and `done`=1 at T+1.
  - `hi`/`lo` unchanged.
- **Not defined:**
  - DIV by zero runs normally; the result is whatever the divider produces.
  - `div_zero` is tied to 0.

## Structure
- **`muldiv_pkg`:** op encodings; state enum (IDLE/MRUN/DRUN); default cycle constants.
- **Sub-module `muldiv_cnt`:** CNT_W-bit run counter with clear and a terminal flag comparing against the selected N.
- **Controller:** FSM, operand latches, and HI/LO registers.

## Test plan
- Reset, then MULT a=7, b=-3 → `mult_start` at T+1, `done` at T+35, `hi`=FFFFFFFF, `lo`=FFFFFFEB, `busy` high for 34 cycles.
- DIV a=100, b=7 → `lo`=14, `hi`=2, `done` at T+35; then MULT issued in the `done` cycle is accepted.
- DIV a=5, b=0 with the macro → `div_zero`=`done`=1 at T+1, no `div_start`, HI/LO unchanged; without the macro → `div_start` pulses and DRUN lasts 34 cycles.
- MULT, then `cancel` at run cycle 10 → IDLE, `unit_clr` pulse, no `done`, HI/LO retain prior values; `cancel` coincident with the final cycle also suppresses the write.
- `req` with MULT asserted during run cycle 5 → ignored; MTHI a=0xDEADBEEF from idle → `hi`=DEADBEEF, `done` at T+1, `busy` stays 0.
- `rst` asserted at run cycle 20 → all outputs take their reset values next edge; `unit_clr`=1 in the first cycle after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, controller states and default run lengths for the HI/LO sequencer
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MRUN = 2'b01,
        ST_DRUN = 2'b10
    } state_e;

    localparam int MULT_CYCLES_DEF = 34;
    localparam int DIV_CYCLES_DEF  = 34;
    localparam int CNT_W_DEF       = 6;

endpackage

// File: rtl/muldiv_cnt.sv
// rtl/muldiv_cnt.sv - run-cycle counter with clear and a terminal flag against the selected last count
module muldiv_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign term  = (count_q == last);

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - MIPS HI/LO sequencer: MULT/DIV/MTHI/MTLO with start pulses, stall and flush.
// Optional macro MULDIV_DIVZERO_EN: DIV by zero is trapped in IDLE and flagged on div_zero.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic [31:0] mult_high,
    input  logic [31:0] mult_low,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        mult_start,
    output logic        div_start,
    output logic        unit_clr,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    state_e      state_d, state_q;
    logic [31:0] op_a_d, op_a_q, op_b_d, op_b_q;
    logic [31:0] hi_d, hi_q, lo_d, lo_q;
    logic        mult_start_d, mult_start_q;
    logic        div_start_d, div_start_q;
    logic        unit_clr_d, unit_clr_q;
    logic        done_d, done_q;
    logic        div_zero_d, div_zero_q;

    op_e             op_s;
    logic            cnt_clr;
    logic            cnt_en;
    logic [CNT_W-1:0] cnt_last;
    logic [CNT_W-1:0] cnt_val;
    logic            cnt_term;

    assign op_s     = op_e'(op);
    assign cnt_en   = (state_q != ST_IDLE);
    assign cnt_last = (state_q == ST_MRUN) ? MULT_LAST : DIV_LAST;

    muldiv_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .last  (cnt_last),
        .count (cnt_val),
        .term  (cnt_term)
    );

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mult_start_d = 1'b0;
        div_start_d  = 1'b0;
        unit_clr_d   = 1'b0;
        done_d       = 1'b0;
        div_zero_d   = 1'b0;
        cnt_clr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // cancel in the same cycle as req squashes the request entirely
                if (req && !cancel) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    cnt_clr = 1'b1;
                    case (op_s)
                        OP_MULT: begin
                            state_d      = ST_MRUN;
                            mult_start_d = 1'b1;
                        end
                        OP_DIV: begin
`ifdef MULDIV_DIVZERO_EN
                            if (b == '0) begin
                                div_zero_d = 1'b1;
                                done_d     = 1'b1;
                            end else begin
                                state_d     = ST_DRUN;
                                div_start_d = 1'b1;
                            end
`else
                            state_d     = ST_DRUN;
                            div_start_d = 1'b1;
`endif
                        end
                        OP_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MRUN, ST_DRUN: begin
                // flush wins over a completion landing in the same cycle
                if (cancel) begin
                    state_d    = ST_IDLE;
                    unit_clr_d = 1'b1;
                end else if (cnt_term) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (state_q == ST_MRUN) begin
                        hi_d = mult_high;
                        lo_d = mult_low;
                    end else begin
                        hi_d = div_rem;
                        lo_d = div_quot;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            unit_clr_q   <= 1'b1;
            done_q       <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            unit_clr_q   <= unit_clr_d;
            done_q       <= done_d;
            div_zero_q   <= div_zero_d;
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign mult_start = mult_start_q;
    assign div_start  = div_start_q;
    assign unit_clr   = unit_clr_q;
    assign done       = done_q;
    assign div_zero   = div_zero_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
